// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite blitter: default geometry, address widths
// and the blitter FSM state encoding.
package sprite_pkg;

    localparam int DEFAULT_SPR_W = 20;
    localparam int DEFAULT_SPR_H = 20;
    localparam int DEFAULT_FB_W  = 320;
    localparam int DEFAULT_FB_H  = 240;
    localparam logic [7:0] DEFAULT_TRANSPARENT_IDX = 8'h00;

    localparam int PIX_W  = 8;
    localparam int POS_W  = 10;
    localparam int ROM_AW = 9;
    localparam int FB_AW  = 17;
    localparam int ROW_W  = 9;
    localparam int COL_W  = 9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } blit_state_t;

endpackage

// File: rtl/blit_raster_counter.sv
// Raster-order sprite pixel counter: sx runs across a row, then wraps while sy advances.
// 'last' flags the bottom-right pixel so the FSM knows when the final read has been issued.
module blit_raster_counter
    import sprite_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_SPR_W,
    parameter int HEIGHT = DEFAULT_SPR_H,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic          vga_clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [XW-1:0] sx,
    output logic [YW-1:0] sy,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    assign last = (sx == X_MAX) && (sy == Y_MAX);

    always_ff @(posedge vga_clk) begin
        if (reset || clear) begin
            sx <= '0;
            sy <= '0;
        end else if (enable) begin
            if (sx == X_MAX) begin
                sx <= '0;
                sy <= (sy == Y_MAX) ? '0 : sy + YW'(1);
            end else begin
                sx <= sx + XW'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite from the palette-index ROM into the framebuffer RAM, skipping
// transparent and off-screen pixels. All outputs are registered.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int         SPR_W           = DEFAULT_SPR_W,
    parameter int         SPR_H           = DEFAULT_SPR_H,
    parameter int         FB_W            = DEFAULT_FB_W,
    parameter int         FB_H            = DEFAULT_FB_H,
    parameter logic [7:0] TRANSPARENT_IDX = DEFAULT_TRANSPARENT_IDX
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [POS_W-1:0]  pos_x,
    input  logic [POS_W-1:0]  pos_y,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_q,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [PIX_W-1:0]  fb_wdata,
    output logic              fb_we
);

    localparam int CX_W = $clog2(SPR_W);
    localparam int CY_W = $clog2(SPR_H);
    localparam int CW   = POS_W + 1;

    blit_state_t state, state_next;

    logic [POS_W-1:0]  base_x, base_y;
    logic [CX_W-1:0]   sx;
    logic [CY_W-1:0]   sy;
    logic              last_pixel;
    logic              issue_en;

    logic [CW-1:0]     fx, fy;
    logic              on_screen;
    logic [ROM_AW-1:0] issue_rom_addr;
    logic [FB_AW-1:0]  issue_fb_addr;

    logic              s1_valid, s1_last, s1_vis;
    logic [FB_AW-1:0]  s1_addr;
    logic              s2_valid, s2_vis;
    logic [FB_AW-1:0]  s2_addr;
    logic              write_hit;

    // Issuing stops once the last pixel sits in the read stage, leaving one RUN cycle spare.
    assign issue_en = (state == RUN) && !(s1_valid && s1_last);

    blit_raster_counter #(
        .WIDTH  (SPR_W),
        .HEIGHT (SPR_H),
        .XW     (CX_W),
        .YW     (CY_W)
    ) u_counter (
        .vga_clk (vga_clk),
        .reset   (reset),
        .clear   (state == IDLE),
        .enable  (issue_en),
        .sx      (sx),
        .sy      (sy),
        .last    (last_pixel)
    );

    // Screen coordinates are formed at 11 bits so positions near 1023 clip instead of wrapping.
    always_comb begin
        fx             = {1'b0, base_x} + CW'(sx);
        fy             = {1'b0, base_y} + CW'(sy);
        on_screen      = (fx < CW'(FB_W)) && (fy < CW'(FB_H));
        issue_rom_addr = ROM_AW'(sx) + ROM_AW'(sy) * ROM_AW'(SPR_W);
        issue_fb_addr  = FB_AW'(fy[ROW_W-1:0]) * FB_AW'(FB_W) + FB_AW'(fx[COL_W-1:0]);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (s1_valid && s1_last) state_next = DRAIN;
            DRAIN:   state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign write_hit = s2_valid && s2_vis && (rom_q != TRANSPARENT_IDX);

    // Stage 1 holds the pixel whose ROM address is out; stage 2 lines up with rom_q.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            base_x   <= '0;
            base_y   <= '0;
            rom_addr <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_vis   <= 1'b0;
            s1_addr  <= '0;
            s2_valid <= 1'b0;
            s2_vis   <= 1'b0;
            s2_addr  <= '0;
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_wdata <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                base_x <= pos_x;
                base_y <= pos_y;
            end
            s1_valid <= issue_en;
            s1_last  <= issue_en && last_pixel;
            if (issue_en) begin
                rom_addr <= issue_rom_addr;
                s1_vis   <= on_screen;
                s1_addr  <= issue_fb_addr;
            end
            s2_valid <= s1_valid;
            s2_vis   <= s1_vis;
            s2_addr  <= s1_addr;
            fb_we    <= write_hit;
            if (write_hit) begin
                fb_addr  <= s2_addr;
                fb_wdata <= rom_q;
            end
            busy <= (state == RUN) || (state == DRAIN);
            done <= (state == FIN);
        end
    end

endmodule
